// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared types and helpers for the truth-table sweeper
package tt_sweep_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  // Reflected Gray code of a vector index
  function automatic logic [7:0] to_gray(input logic [7:0] i);
    return i ^ (i >> 1);
  endfunction

  // Width of a hold counter that must represent 0..hold_cycles
  function automatic int hold_cnt_w(input int hold_cycles);
    return $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - control, status and DUT-facing signals of the sweeper
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
) ();
  logic            start;
  logic            abort;
  logic            dut_y;
  logic [N_IN-1:0] stim_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            fail_valid;
  logic [N_IN-1:0] fail_vec;

  modport master (
    input  start, abort, dut_y,
    output stim_out, busy, done, pass, err_count, fail_valid, fail_vec
  );

  modport slave (
    output start, abort, dut_y,
    input  stim_out, busy, done, pass, err_count, fail_valid, fail_vec
  );
endinterface

// File: rtl/sweep_hold_timer.sv
// rtl/sweep_hold_timer.sv - loadable down-counter that flags expiry at zero
module sweep_hold_timer #(
  parameter int           W      = 5,
  parameter logic [W-1:0] RELOAD = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [W-1:0] count_q;

  // Reload takes priority; otherwise count down while enabled and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= RELOAD;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expire = (count_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive vector driver and truth-table checker
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int                    N_IN        = 3,
  parameter int                    HOLD_CYCLES = 20,
  parameter logic [(1<<N_IN)-1:0]  EXP_TT      = 8'hE8,
  parameter int                    GRAY_ORDER  = 0
) (
  input logic                    clk,
  input logic                    rst_n,
  truth_table_sweeper_if.master  bus
);

  localparam int              CW       = hold_cnt_w(HOLD_CYCLES);
  localparam logic [CW-1:0]   RELOAD   = CW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] LAST_IDX = '1;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, stim_q, fail_vec_q;
  logic [N_IN-1:0] next_idx, next_vec;
  logic [N_IN:0]   err_q;
  logic            fail_valid_q, pass_q;
  logic            expire, load, sample, finish, clear, go_idle, mismatch;

  sweep_hold_timer #(
    .W      (CW),
    .RELOAD (RELOAD)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .en     (state_q == HOLD),
    .expire (expire)
  );

  assign next_idx = idx_q + 1'b1;
  assign next_vec = (GRAY_ORDER != 0) ? N_IN'(to_gray(8'(next_idx))) : next_idx;
  // Case-inequality so an unknown DUT output is scored as a failure
  assign mismatch = (bus.dut_y !== EXP_TT[stim_q]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath strobes; abort overrides both start and sampling
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    sample  = 1'b0;
    finish  = 1'b0;
    clear   = 1'b0;
    go_idle = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      go_idle = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_d = HOLD;
            clear   = 1'b1;
            load    = 1'b1;
          end
        end
        HOLD: begin
          if (expire) begin
            sample = 1'b1;
            if (idx_q == LAST_IDX) begin
              finish  = 1'b1;
              state_d = DONE;
            end else begin
              load = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Vector stepping and scoreboard; partial results survive an abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      stim_q       <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      pass_q       <= 1'b0;
    end else if (go_idle) begin
      stim_q <= '0;
      pass_q <= 1'b0;
    end else if (clear) begin
      idx_q        <= '0;
      stim_q       <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      pass_q       <= 1'b0;
    end else if (sample) begin
      if (mismatch) begin
        err_q <= err_q + 1'b1;
        if (!fail_valid_q) begin
          fail_valid_q <= 1'b1;
          fail_vec_q   <= stim_q;
        end
      end
      if (finish) begin
        stim_q <= '0;
        pass_q <= (err_q == '0) && !mismatch;
      end else begin
        idx_q  <= next_idx;
        stim_q <= next_vec;
      end
    end
  end

  assign bus.stim_out   = stim_q;
  assign bus.busy       = (state_q == HOLD);
  assign bus.done       = (state_q == DONE);
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(3)) ia ();
  truth_table_sweeper_if #(.N_IN(3)) ib ();
  truth_table_sweeper_if #(.N_IN(4)) ic ();

  truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(20), .EXP_TT(8'hE8), .GRAY_ORDER(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(6), .EXP_TT(8'hE8), .GRAY_ORDER(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  truth_table_sweeper #(.N_IN(4), .HOLD_CYCLES(1), .EXP_TT(16'h6996), .GRAY_ORDER(0))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

  logic        go [3];
  logic        ab [3];
  logic        stuck [3];
  logic [15:0] fmask [3];
  logic [15:0] xmask [3];
  logic        xval;

  // Reference circuits: majority of three for a/b, four-input parity for c
  function automatic logic ref_y(input int d, input logic [3:0] v);
    return (d == 2) ? ^v : ($countones(v[2:0]) >= 2);
  endfunction

  // Circuit under test models with stuck-at, inversion and unknown-level faults
  assign ia.dut_y = xmask[0][ia.stim_out] ? xval :
                    (stuck[0] ? 1'b0 : ref_y(0, 4'(ia.stim_out)) ^ fmask[0][ia.stim_out]);
  assign ib.dut_y = xmask[1][ib.stim_out] ? xval :
                    (stuck[1] ? 1'b0 : ref_y(1, 4'(ib.stim_out)) ^ fmask[1][ib.stim_out]);
  assign ic.dut_y = xmask[2][ic.stim_out] ? xval :
                    (stuck[2] ? 1'b0 : ref_y(2, ic.stim_out) ^ fmask[2][ic.stim_out]);

  assign ia.start = go[0];
  assign ib.start = go[1];
  assign ic.start = go[2];
  assign ia.abort = ab[0];
  assign ib.abort = ab[1];
  assign ic.abort = ab[2];

  logic [7:0] s_stim [3];
  logic [7:0] s_fvec [3];
  logic [8:0] s_err  [3];
  logic       s_busy [3];
  logic       s_done [3];
  logic       s_pass [3];
  logic       s_fv   [3];

  assign s_stim[0] = 8'(ia.stim_out);
  assign s_stim[1] = 8'(ib.stim_out);
  assign s_stim[2] = 8'(ic.stim_out);
  assign s_fvec[0] = 8'(ia.fail_vec);
  assign s_fvec[1] = 8'(ib.fail_vec);
  assign s_fvec[2] = 8'(ic.fail_vec);
  assign s_err[0]  = 9'(ia.err_count);
  assign s_err[1]  = 9'(ib.err_count);
  assign s_err[2]  = 9'(ic.err_count);
  assign s_busy[0] = ia.busy;
  assign s_busy[1] = ib.busy;
  assign s_busy[2] = ic.busy;
  assign s_done[0] = ia.done;
  assign s_done[1] = ib.done;
  assign s_done[2] = ic.done;
  assign s_pass[0] = ia.pass;
  assign s_pass[1] = ib.pass;
  assign s_pass[2] = ic.pass;
  assign s_fv[0]   = ia.fail_valid;
  assign s_fv[1]   = ib.fail_valid;
  assign s_fv[2]   = ic.fail_valid;

  function automatic int nin_of(input int d);
    return (d == 2) ? 4 : 3;
  endfunction

  function automatic int hold_of(input int d);
    return (d == 0) ? 20 : ((d == 1) ? 6 : 1);
  endfunction

  function automatic int vec_of(input int d, input int i);
    return (d == 1) ? (i ^ (i >> 1)) : i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scores the first upto vectors in application order
  task automatic model(input int d, input int upto, output int errs, output int first);
    int  v;
    logic bad;
    errs  = 0;
    first = -1;
    for (int i = 0; i < upto; i++) begin
      v = vec_of(d, i);
      if (xmask[d][v])  bad = (xval !== ref_y(d, 4'(v)));
      else if (stuck[d]) bad = (ref_y(d, 4'(v)) !== 1'b0);
      else              bad = fmask[d][v];
      if (bad) begin
        errs++;
        if (first < 0) first = v;
      end
    end
  endtask

  function automatic logic [31:0] idle_word(input int d);
    return {s_busy[d], s_done[d], s_pass[d], s_fv[d], s_err[d], s_fvec[d], s_stim[d]};
  endfunction

  // Full sweep: per-cycle trace of vectors and status, then final results
  task automatic sweep(input int d, input string tag, input int mid);
    int nv, hold, errs, first, bad;
    nv   = 1 << nin_of(d);
    hold = hold_of(d);
    model(d, nv, errs, first);
    go[d] = 1'b1;
    @(negedge clk);
    go[d] = 1'b0;
    bad = 0;
    for (int n = 0; n < nv * hold; n++) begin
      if (s_stim[d] !== 8'(vec_of(d, n / hold)) || s_busy[d] !== 1'b1 || s_done[d] !== 1'b0)
        bad++;
      go[d] = (n == mid);
      @(negedge clk);
    end
    go[d] = 1'b0;
    chk({tag, "_trace"}, bad, 0);
    chk({tag, "_done"}, {s_done[d], s_busy[d]}, 2'b10);
    chk({tag, "_stim"}, s_stim[d], 0);
    chk({tag, "_err"}, s_err[d], errs);
    chk({tag, "_pass"}, s_pass[d], (errs == 0));
    chk({tag, "_fv"}, s_fv[d], (first >= 0));
    chk({tag, "_fvec"}, s_fvec[d], (first >= 0) ? first : 0);
  endtask

  initial begin
    int e, f, bad;
    xval  = 1'bx;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      go[d] = 1'b0; ab[d] = 1'b0; stuck[d] = 1'b0;
      fmask[d] = '0; xmask[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_a", idle_word(0), 0);
    chk("reset_b", idle_word(1), 0);
    chk("reset_c", idle_word(2), 0);

    sweep(0, "a_clean", -1);
    stuck[0] = 1'b1;
    sweep(0, "a_stuck0", -1);
    stuck[0] = 1'b0;
    for (int r = 0; r < 3; r++) begin
      fmask[0] = 16'($urandom_range(0, 255));
      sweep(0, "a_rand", -1);
    end
    fmask[0] = '0;
    sweep(0, "a_midstart", 50);

    fmask[0] = 16'($urandom_range(1, 255));
    go[0] = 1'b1;
    @(negedge clk);
    go[0] = 1'b0;
    repeat (70) @(negedge clk);
    ab[0] = 1'b1;
    @(negedge clk);
    ab[0] = 1'b0;
    model(0, 70 / 20, e, f);
    chk("abort_state", {s_busy[0], s_done[0], s_pass[0], s_stim[0]}, 0);
    chk("abort_err", s_err[0], e);
    chk("abort_fv", s_fv[0], (f >= 0));
    chk("abort_fvec", s_fvec[0], (f >= 0) ? f : 0);
    go[0] = 1'b1;
    @(negedge clk);
    go[0] = 1'b0;
    chk("restart", {s_busy[0], s_fv[0], s_err[0], s_stim[0]}, {1'b1, 18'd0});
    ab[0] = 1'b1;
    @(negedge clk);
    ab[0] = 1'b0;
    go[0] = 1'b1; ab[0] = 1'b1;
    @(negedge clk);
    go[0] = 1'b0; ab[0] = 1'b0;
    chk("start_abort_same", {s_busy[0], s_done[0]}, 0);

    fmask[0] = 16'h0001;
    go[0] = 1'b1;
    @(negedge clk);
    go[0] = 1'b0;
    repeat (45) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", idle_word(0), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_busy[0] !== 1'b0 || s_done[0] !== 1'b0) bad++;
    end
    chk("reset_no_done", bad, 0);
    fmask[0] = '0;

    sweep(1, "b_clean", -1);
    fmask[1] = 16'h0040;
    sweep(1, "b_inv6", -1);
    for (int r = 0; r < 2; r++) begin
      fmask[1] = 16'($urandom_range(0, 255));
      sweep(1, "b_rand", -1);
    end

    sweep(2, "c_clean", -1);
    xmask[2] = 16'h0200;
    sweep(2, "c_x9", -1);
    xmask[2] = '0;
    for (int r = 0; r < 2; r++) begin
      fmask[2] = 16'($urandom_range(0, 65535));
      sweep(2, "c_rand", -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
